lc3b_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache for the LC-3b CPU, sitting between the CPU memory port (16-bit words, byte masks) and physical memory (128-bit lines). It generalises the single-configuration cache with configurable ways and sets, LRU replacement, dirty-line writeback and saturating hit/miss counters. Tag/valid/dirty/LRU state, the controller FSM and the datapath are all inside this block.

---
 rtl/lc3b_assoc_cache_if.sv | 23 ++
 rtl/lc3b_assoc_cache.sv | 201 ++++++++++++++++++++
 tb/tb_lc3b_assoc_cache.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_assoc_cache_if.sv
// CPU-side memory port of the LC-3b cache: request, byte mask, data and
// single-cycle completion pulse grouped into one bundle.
interface lc3b_assoc_cache_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    // CPU (request issuer)
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    // Cache (request responder)
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/lc3b_assoc_cache.sv
// N-way set-associative, write-back, write-allocate cache for the LC-3b.
// Hits complete combinationally in IDLE; misses write back a dirty victim,
// fill the line from physical memory and then re-look-up the held request.
module lc3b_assoc_cache #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lc3b_assoc_cache_if.slave    cpu,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    output logic [127:0]         pmem_wdata,
    input  logic                 pmem_resp,
    input  logic [127:0]         pmem_rdata,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 12 - IDX_W;
    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t           state_q, state_d;
    logic [AGE_W-1:0] victim_q, victim_d;
    logic             refill_q, refill_d;
    logic [15:0]      hit_count_q, hit_count_d;
    logic [15:0]      miss_count_q, miss_count_d;

    // Address decomposition; bit 0 is a byte offset inside the word and unused.
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word_sel;
    logic [6:0]       lo_bit, hi_bit;
    logic             addr_unused;
    logic             req;

    assign idx         = cpu.mem_address[IDX_W+3:4];
    assign tag         = cpu.mem_address[15:IDX_W+4];
    assign word_sel    = cpu.mem_address[3:1];
    assign lo_bit      = {word_sel, 4'b0000};
    assign hi_bit      = lo_bit + 7'd8;
    assign addr_unused = cpu.mem_address[0];
    assign req         = cpu.mem_read | cpu.mem_write;

    // Per-way read ports of the currently indexed set.
    logic [WAYS-1:0]                valid_rd, dirty_rd, hit_vec;
    logic [WAYS-1:0][TAG_W-1:0]     tag_rd;
    logic [WAYS-1:0][127:0]         line_rd;
    logic [WAYS-1:0][AGE_W-1:0]     age_rd;

    logic             hit;
    logic [AGE_W-1:0] hit_way, victim_sel, max_age, hit_age;
    logic             lookup_hit, write_hit, fill_done;

    assign hit_age    = age_rd[hit_way];
    assign lookup_hit = (state_q == IDLE) && req && hit;
    assign write_hit  = lookup_hit && cpu.mem_write;
    assign fill_done  = (state_q == FILL) && pmem_resp;

    // Tag match and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_sel = '0;
        max_age    = age_rd[0];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (age_rd[w] > max_age) begin
                max_age    = age_rd[w];
                victim_sel = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_rd[w]) victim_sel = AGE_W'(w);
        end
    end

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [127:0]     data_mem [SETS];
            logic [TAG_W-1:0] tag_mem  [SETS];
            logic [AGE_W-1:0] age_mem  [SETS];
            logic [SETS-1:0]  valid_mem, dirty_mem;
            logic             sel_fill, sel_write;

            assign sel_fill    = fill_done && (victim_q == AGE_W'(gi));
            assign sel_write   = write_hit && (hit_way == AGE_W'(gi));
            assign line_rd[gi] = data_mem[idx];
            assign tag_rd[gi]  = tag_mem[idx];
            assign age_rd[gi]  = age_mem[idx];
            assign valid_rd[gi] = valid_mem[idx];
            assign dirty_rd[gi] = dirty_mem[idx];
            assign hit_vec[gi]  = valid_mem[idx] && (tag_mem[idx] == tag);

            // Line data and tag: loaded on fill, byte-merged on write hit.
            always_ff @(posedge clk) begin
                if (sel_fill) begin
                    data_mem[idx] <= pmem_rdata;
                    tag_mem[idx]  <= tag;
                end else if (sel_write) begin
                    if (cpu.mem_byte_enable[0]) data_mem[idx][lo_bit +: 8] <= cpu.mem_wdata[7:0];
                    if (cpu.mem_byte_enable[1]) data_mem[idx][hi_bit +: 8] <= cpu.mem_wdata[15:8];
                end
            end

            // Valid/dirty: fill makes the line clean, a masked write makes it dirty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_mem <= '0;
                    dirty_mem <= '0;
                end else if (sel_fill) begin
                    valid_mem[idx] <= 1'b1;
                    dirty_mem[idx] <= 1'b0;
                end else if (sel_write && (cpu.mem_byte_enable != 2'b00)) begin
                    dirty_mem[idx] <= 1'b1;
                end
            end

            // LRU ages: accessed way becomes youngest, younger ways age by one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) age_mem[s] <= AGE_W'(gi);
                end else if (lookup_hit) begin
                    if (hit_way == AGE_W'(gi)) age_mem[idx] <= '0;
                    else if (age_mem[idx] < hit_age) age_mem[idx] <= age_mem[idx] + 1'b1;
                end
            end
        end
    endgenerate

    assign pmem_wdata = line_rd[victim_q];
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Controller state, victim pointer, refill flag and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            refill_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next state and all handshake outputs.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        refill_d      = refill_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        cpu.mem_resp  = 1'b0;
        cpu.mem_rdata = '0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        cpu.mem_resp  = 1'b1;
                        cpu.mem_rdata = line_rd[hit_way][lo_bit +: 16];
                        refill_d      = 1'b0;
                        if (!refill_q && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
                    end else begin
                        victim_d = victim_sel;
                        refill_d = 1'b1;
                        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
                        state_d = (valid_rd[victim_sel] && dirty_rd[victim_sel]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_rd[victim_q], idx, 4'h0};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {cpu.mem_address[15:4], 4'h0};
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3b_assoc_cache.sv
// Self-checking bench for lc3b_assoc_cache (WAYS=2, SETS=8): directed vector
// table, reset-in-fill and counter saturation sequences, then random traffic
// compared with a timestamp-LRU reference model of the cache.
module tb_lc3b_assoc_cache;
    localparam int WAYS = 2;
    localparam int SETS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address, hit_count, miss_count;
    logic [127:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    lc3b_assoc_cache_if cif();

    lc3b_assoc_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n), .cpu(cif),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- physical memory responder ----------------
    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } ev_t;
    ev_t evq[$];
    logic [127:0] bmem [int];
    bit  hold_resp = 1'b0;
    bit  last_wr = 1'b0;
    int  wait_cnt = 0;
    int  stale_cnt = 0;
    int  both_cnt = 0;
    int  bad_addr = 0;

    function automatic logic [127:0] line_init(input logic [15:0] a);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = {a[15:4], 4'(i * 2)} ^ 16'h5A5A;
        return r;
    endfunction

    function automatic logic [127:0] bfetch(input logic [15:0] a);
        if (bmem.exists(int'(a))) return bmem[int'(a)];
        return line_init(a);
    endfunction

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) both_cnt++;
            if ((pmem_read || pmem_write) && (pmem_address[3:0] != 4'h0)) bad_addr++;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                if (last_wr ? pmem_write : pmem_read) stale_cnt++;
            end else if (rst_n && !hold_resp && (pmem_read || pmem_write)) begin
                if (wait_cnt == 0) wait_cnt = $urandom_range(1, 3);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    last_wr = pmem_write;
                    if (pmem_write) bmem[int'(pmem_address)] = pmem_wdata;
                    else pmem_rdata = bfetch(pmem_address);
                    evq.push_back('{pmem_write, pmem_address, pmem_write ? pmem_wdata : pmem_rdata});
                    pmem_resp = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- CPU-side driver ----------------
    task automatic do_access(input bit wr, input logic [15:0] a, input logic [1:0] be,
                             input logic [15:0] wd, output int waits, output logic [15:0] rd);
        bit done;
        evq.delete();
        cif.mem_read        = !wr;
        cif.mem_write       = wr;
        cif.mem_address     = a;
        cif.mem_byte_enable = be;
        cif.mem_wdata       = wd;
        waits = 0;
        rd    = '0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (cif.mem_resp) begin
                rd   = cif.mem_rdata;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL access_timeout: addr %h got no mem_resp required within 100 cycles", a);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cif.mem_read  = 1'b0;
        cif.mem_write = 1'b0;
    endtask

    task automatic check_events(input string nm, input bit hit, input bit wb, input logic [15:0] wb_addr,
                                input logic [127:0] wb_data, input logic [127:0] wb_mask,
                                input logic [15:0] fill_addr, input int waits);
        int n;
        if (hit) begin
            check({nm, " hit_wait"}, 128'(waits), 128'(0));
            check({nm, " hit_pmem_events"}, 128'(evq.size()), 128'(0));
        end else begin
            n = wb ? 2 : 1;
            check({nm, " miss_pmem_events"}, 128'(evq.size()), 128'(n));
            if (evq.size() == n) begin
                if (wb) begin
                    check({nm, " wb_is_write"}, 128'(evq[0].wr), 128'(1));
                    check({nm, " wb_addr"}, 128'(evq[0].addr), 128'(wb_addr));
                    check({nm, " wb_data"}, evq[0].data & wb_mask, wb_data & wb_mask);
                end
                check({nm, " fill_is_read"}, 128'(evq[n-1].wr), 128'(0));
                check({nm, " fill_addr"}, 128'(evq[n-1].addr), 128'(fill_addr));
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit wr; logic [15:0] addr; logic [1:0] be; logic [15:0] wd;
        bit hit; bit wb; logic [15:0] wb_addr; logic [15:0] wb_w0; logic [15:0] rdata;
    } vec_t;
    localparam int NV = 15;
    vec_t vt [NV];

    function automatic vec_t mk(input bit wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd,
                                input bit hit, input bit wb, input logic [15:0] wba, input logic [15:0] w0,
                                input logic [15:0] rdv);
        return '{wr, a, be, wd, hit, wb, wba, w0, rdv};
    endfunction

    // ---------------- reference model ----------------
    typedef struct { bit v; logic [8:0] tag; bit d; logic [127:0] data; int last; } mline_t;
    mline_t       mc [SETS][WAYS];
    logic [127:0] rmem [int];
    int           tick = 0;

    function automatic logic [127:0] rfetch(input logic [15:0] a);
        if (rmem.exists(int'(a))) return rmem[int'(a)];
        return line_init(a);
    endfunction

    task automatic model_access(input bit wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd,
                                output bit exp_hit, output bit exp_wb, output logic [15:0] wb_addr,
                                output logic [127:0] wb_data, output logic [15:0] exp_rd);
        int s, hw, ws;
        logic [8:0] t;
        s  = int'(a[6:4]);
        t  = a[15:7];
        ws = int'(a[3:1]) * 16;
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (mc[s][w].v && mc[s][w].tag == t) hw = w;
        exp_hit = (hw >= 0);
        exp_wb  = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (hw < 0) begin
            for (int w = 0; w < WAYS; w++) if (!mc[s][w].v && hw < 0) hw = w;
            if (hw < 0) begin
                hw = 0;
                for (int w = 1; w < WAYS; w++) if (mc[s][w].last < mc[s][hw].last) hw = w;
                if (mc[s][hw].d) begin
                    exp_wb  = 1'b1;
                    wb_addr = {mc[s][hw].tag, 3'(s), 4'h0};
                    wb_data = mc[s][hw].data;
                    rmem[int'(wb_addr)] = wb_data;
                end
            end
            mc[s][hw] = '{1'b1, t, 1'b0, rfetch({a[15:4], 4'h0}), 0};
        end
        tick++;
        mc[s][hw].last = tick;
        if (wr) begin
            if (be[0]) mc[s][hw].data[ws +: 8] = wd[7:0];
            if (be[1]) mc[s][hw].data[ws + 8 +: 8] = wd[15:8];
            if (be != 2'b00) mc[s][hw].d = 1'b1;
        end
        exp_rd = mc[s][hw].data[ws +: 16];
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           waits, eh, em, bw;
        logic [15:0]  rd, wba, erd, last_a;
        logic [127:0] wbd, pre;
        bit           eht, ewb, wr;
        logic [1:0]   be;
        logic [15:0]  a, wd;

        cif.mem_read = 1'b0; cif.mem_write = 1'b0; cif.mem_byte_enable = 2'b00;
        cif.mem_address = '0; cif.mem_wdata = '0;
        for (int i = 0; i < 8; i++) pre[i*16 +: 16] = 16'h1234 + 16'(i);
        bmem[16'h0010] = pre;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_resp", 128'(cif.mem_resp), 128'(0));
        check("reset pmem_read", 128'(pmem_read), 128'(0));
        check("reset pmem_write", 128'(pmem_write), 128'(0));
        check("reset pmem_address", 128'(pmem_address), 128'(0));
        check("reset hit_count", 128'(hit_count), 128'(0));
        check("reset miss_count", 128'(miss_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vt[0]  = mk(0, 16'h0010, 2'b11, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h1234);
        vt[1]  = mk(0, 16'h0012, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'h1235);
        vt[2]  = mk(1, 16'h0010, 2'b01, 16'hBEEF, 1, 0, 16'h0, 16'h0, 16'h0000);
        vt[3]  = mk(0, 16'h0010, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'h12EF);
        vt[4]  = mk(0, 16'h0090, 2'b11, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h5ACA);
        vt[5]  = mk(0, 16'h0010, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'h12EF);
        vt[6]  = mk(0, 16'h0110, 2'b11, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h5B4A);
        vt[7]  = mk(0, 16'h0010, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'h12EF);
        vt[8]  = mk(1, 16'h0090, 2'b11, 16'hCAFE, 0, 0, 16'h0, 16'h0, 16'h0000);
        vt[9]  = mk(0, 16'h0090, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'hCAFE);
        vt[10] = mk(0, 16'h0110, 2'b11, 16'h0000, 0, 1, 16'h0010, 16'h12EF, 16'h5B4A);
        vt[11] = mk(1, 16'h0092, 2'b00, 16'hFFFF, 1, 0, 16'h0, 16'h0, 16'h0000);
        vt[12] = mk(0, 16'h0092, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'h5AC8);
        vt[13] = mk(1, 16'h0094, 2'b10, 16'hAB00, 1, 0, 16'h0, 16'h0, 16'h0000);
        vt[14] = mk(0, 16'h0094, 2'b11, 16'h0000, 1, 0, 16'h0, 16'h0, 16'hABCE);

        eh = 0;
        em = 0;
        for (int i = 0; i < NV; i++) begin
            do_access(vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd, waits, rd);
            if (vt[i].hit) eh++; else em++;
            $display("[TB] row %0d %s addr=%h be=%b wd=%h rdata=%h waits=%0d", i,
                     vt[i].wr ? "W" : "R", vt[i].addr, vt[i].be, vt[i].wd, rd, waits);
            check_events($sformatf("row%0d", i), vt[i].hit, vt[i].wb, vt[i].wb_addr,
                         128'(vt[i].wb_w0), 128'hFFFF, {vt[i].addr[15:4], 4'h0}, waits);
            if (!vt[i].wr) check($sformatf("row%0d rdata", i), 128'(rd), 128'(vt[i].rdata));
            check($sformatf("row%0d hit_count", i), 128'(hit_count), 128'(eh));
            check($sformatf("row%0d miss_count", i), 128'(miss_count), 128'(em));
        end

        // Reset asserted while a fill is outstanding
        hold_resp = 1'b1;
        cif.mem_read = 1'b1;
        cif.mem_address = 16'h0200;
        waits = 0;
        while (!pmem_read && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("rstfill pmem_read_before", 128'(pmem_read), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstfill pmem_read_after", 128'(pmem_read), 128'(0));
        check("rstfill hit_count", 128'(hit_count), 128'(0));
        check("rstfill miss_count", 128'(miss_count), 128'(0));
        cif.mem_read = 1'b0;
        hold_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_access(0, 16'h0200, 2'b11, 16'h0, waits, rd);
        $display("[TB] rstfill reread addr=0200 rdata=%h waits=%0d", rd, waits);
        check_events("rstfill reread", 0, 0, 16'h0, 128'h0, 128'h0, 16'h0200, waits);
        check("rstfill reread rdata", 128'(rd), 128'(16'h585A));
        check("rstfill reread miss_count", 128'(miss_count), 128'(1));

        // Fresh start for the random phase
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mc[s][w] = '{1'b0, 9'h0, 1'b0, 128'h0, 0};
        eh = 0;
        em = 0;
        last_a = '0;
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            a  = 16'h8000 | 16'($urandom_range(0, 3) << 7) | 16'($urandom_range(0, 7) << 4)
                 | 16'($urandom_range(0, 7) << 1);
            model_access(wr, a, be, wd, eht, ewb, wba, wbd, erd);
            do_access(wr, a, be, wd, waits, rd);
            if (eht) eh++; else em++;
            last_a = a;
            $display("[TB] rand %0d %s addr=%h be=%b wd=%h rdata=%h waits=%0d", i,
                     wr ? "W" : "R", a, be, wd, rd, waits);
            check_events($sformatf("rand%0d", i), eht, ewb, wba, wbd, {128{1'b1}},
                         {a[15:4], 4'h0}, waits);
            if (!wr) check($sformatf("rand%0d rdata", i), 128'(rd), 128'(erd));
        end
        check("rand hit_count", 128'(hit_count), 128'(eh));
        check("rand miss_count", 128'(miss_count), 128'(em));

        // Hit counter saturation
        force dut.hit_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.hit_count_q;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) begin
            do_access(0, last_a, 2'b11, 16'h0, waits, rd);
            $display("[TB] sat %0d addr=%h hit_count=%h", k, last_a, hit_count);
            check($sformatf("sat%0d hit_count", k), 128'(hit_count), 128'(16'hFFFF));
        end

        check("pmem read+write overlap count", 128'(both_cnt), 128'(0));
        check("pmem request held after resp count", 128'(stale_cnt), 128'(0));
        check("pmem address low nibble nonzero count", 128'(bad_addr), 128'(0));
        bw = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
